ls_unit: RTL and testbench
==========================

Name: ls_unit

Overview:
- Parametrised load/store unit between the execute stage and the data-memory port.
- Generalises the single-width word load/store to byte, half, word and (when DATA_W=64) double accesses.
- Provides byte-lane strobes, load sign/zero extension, misalignment and illegal-command detection, and an optional bus timeout.
- Runs one transaction at a time and drives a registered request/ready handshake toward memory.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; legal values are 32 and 64.
- TIMEOUT, 0, maximum cycles a request may wait for ready; 0 disables the timeout.

Ports:
- clk  in  1  clock; every register updates on the rising edge.
- rstb  in  1  synchronous reset, active-high: asserted (1) = reset, despite the name.
- rw_addr  in  ADDR_W  byte address.
- wr_en  in  1  store command.
- rd_en  in  1  load command.
- size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double.
- is_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- wr_data  in  DATA_W  store data, right-aligned.
- busy  out  1  unit is not in IDLE.
- rd_data  out  DATA_W  extended load result.
- rd_done  out  1  one-cycle pulse: load finished.
- wr_done  out  1  one-cycle pulse: store finished.
- err  out  1  valid only with a done pulse.
- err_code  out  2  0 = none, 1 = misaligned, 2 = illegal, 3 = timeout.
- d_addr  out  ADDR_W  lane-aligned address (low log2(DATA_W/8) bits forced to 0).
- d_wr_data  out  DATA_W  store data shifted into its byte lanes.
- d_wr_strb  out  DATA_W/8  byte-lane enables.
- d_wr_req  out  1  write request.
- d_wr_ready  in  1  write accepted.
- d_rd_req  out  1  read request.
- d_rd_ready  in  1  read data valid.
- d_rd_data  in  DATA_W  read data.

Behaviour:
- Reset: rstb=1 at a rising edge forces state IDLE and all outputs to 0, including rd_data, err_code, strobes and requests. Reset mid-transaction drops the request in the next cycle, and no done pulse is produced.
- States:
  - IDLE: a command is sampled only here.
  - REQ: request held to memory.
  - RESP: one cycle, done pulse.
- IDLE, command present: check order is illegal, then misaligned.
  - illegal: wr_en and rd_en both high, or size=3 with DATA_W=32 → RESP with err=1, code 2. No memory access; wr_done pulses if wr_en, else rd_done.
  - misaligned: rw_addr not a multiple of 2^size → RESP with err=1, code 1. No memory access; matching done pulses.
  - legal: register addr, data and strobes, then go to REQ.
- REQ:
  - The matching d_*_req is held high, and d_addr, d_wr_data and d_wr_strb are held stable, until ready is sampled high.
  - Ready seen → RESP in the next cycle. For loads, d_rd_data is captured in the same cycle as ready.
  - First request cycle is the cycle after the command, so minimum latency is command → done = 2 cycles when ready is already high.
- Timeout:
  - A counter clears on REQ entry and increments each REQ cycle without ready.
  - If TIMEOUT>0 and the counter reaches TIMEOUT, the request is dropped and the unit goes to RESP with err=1, code 3.
  - Ready in the same cycle as the counter reaching TIMEOUT counts as success.
- RESP: done is high for exactly one cycle, then IDLE. Commands presented during REQ or RESP are ignored; the upstream stage must hold the command until it sees done.
- Lanes:
  - lane = rw_addr mod (DATA_W/8).
  - d_wr_strb has 2^size consecutive bits set starting at lane.
  - d_wr_data = wr_data shifted left by lane*8.
  - Load result = d_rd_data shifted right by lane*8, truncated to 2^size bytes, then sign- or zero-extended to DATA_W.
  - rd_data holds its value until the next load completes; a failed load drives rd_data = 0.

Test Plan:
1. DATA_W=32. SW addr 0x100, data 0xDEADBEEF, d_wr_ready tied 1 → d_wr_req high one cycle, d_addr 0x100, strb 0xF; wr_done 2 cycles after the command, err=0.
2. SB addr 0x103, data 0x000000A5 → d_wr_data 0xA5000000, strb 0x8.
3. LH addr 0x102, d_rd_data 0x8001_1234, ready after 3 wait cycles:
   - signed → rd_data 0xFFFF8001;
   - unsigned → 0x00008001;
   - d_rd_req held 4 cycles with d_addr stable.
4. LW addr 0x101 → no d_rd_req, rd_done with err=1, code 1. wr_en and rd_en together → err code 2. size=3 at DATA_W=32 → err code 2.
5. TIMEOUT=4, ready never asserted → d_rd_req high 4 cycles then low, rd_done with err code 3. Repeat with ready arriving exactly in the 4th cycle → success.
6. rstb=1 during REQ → request low the following cycle, no done pulse; then DATA_W=64 LD addr 0x8 returns the full 64-bit word with strb 0xFF on stores.

Source files
------------

// File: rtl/ls_unit.sv
// Load/store unit: one transaction at a time between execute and the data-memory port.
// Handles byte-lane placement, load extension, error detection and an optional request timeout.
module ls_unit #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 0
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic [ADDR_W-1:0]   rw_addr,
    input  logic                wr_en,
    input  logic                rd_en,
    input  logic [1:0]          size,
    input  logic                is_unsigned,
    input  logic [DATA_W-1:0]   wr_data,
    output logic                busy,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_done,
    output logic                wr_done,
    output logic                err,
    output logic [1:0]          err_code,
    output logic [ADDR_W-1:0]   d_addr,
    output logic [DATA_W-1:0]   d_wr_data,
    output logic [DATA_W/8-1:0] d_wr_strb,
    output logic                d_wr_req,
    input  logic                d_wr_ready,
    output logic                d_rd_req,
    input  logic                d_rd_ready,
    input  logic [DATA_W-1:0]   d_rd_data
);

    localparam int STRB_W = DATA_W / 8;
    localparam int LANE_W = $clog2(STRB_W);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    typedef enum logic [1:0] {
        CODE_NONE    = 2'd0,
        CODE_MISALGN = 2'd1,
        CODE_ILLEGAL = 2'd2,
        CODE_TIMEOUT = 2'd3
    } code_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   strb_q, strb_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic                is_wr_q, is_wr_d;
    logic                err_q, err_d;
    code_t               code_q, code_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic [31:0]         cnt_q, cnt_d;

    logic [LANE_W-1:0]   lane;
    logic [2:0]          align_mask;
    logic                illegal;
    logic                misaligned;
    logic [STRB_W-1:0]   strb_base;
    logic [DATA_W-1:0]   rd_shifted;
    logic [DATA_W-1:0]   ext_mask;
    logic                ext_bit;
    logic [DATA_W-1:0]   load_ext;
    logic                ready;

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous and active-high on rstb.
    always_ff @(posedge clk) begin
        if (rstb) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            lane_q    <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            is_wr_q   <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= CODE_NONE;
            rd_data_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            lane_q    <= lane_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            is_wr_q   <= is_wr_d;
            err_q     <= err_d;
            code_q    <= code_d;
            rd_data_q <= rd_data_d;
            cnt_q     <= cnt_d;
        end
    end

    // Command decode: lane position, strobe pattern and alignment requirement per size.
    always_comb begin
        lane = rw_addr[LANE_W-1:0];
        unique case (size)
            2'd0:    begin align_mask = 3'b000; strb_base = STRB_W'(8'h01); end
            2'd1:    begin align_mask = 3'b001; strb_base = STRB_W'(8'h03); end
            2'd2:    begin align_mask = 3'b011; strb_base = STRB_W'(8'h0F); end
            default: begin align_mask = 3'b111; strb_base = STRB_W'(8'hFF); end
        endcase
        illegal    = (wr_en && rd_en) || (size == 2'd3 && DATA_W == 32);
        misaligned = |(rw_addr[2:0] & align_mask);
    end

    // Load path: bring the addressed bytes down to bit 0, then extend to full width.
    always_comb begin
        rd_shifted = d_rd_data >> {lane_q, 3'b000};
        unique case (size_q)
            2'd0:    begin ext_mask = DATA_W'(8'hFF);         ext_bit = rd_shifted[7];  end
            2'd1:    begin ext_mask = DATA_W'(16'hFFFF);      ext_bit = rd_shifted[15]; end
            2'd2:    begin ext_mask = DATA_W'(32'hFFFF_FFFF); ext_bit = rd_shifted[31]; end
            default: begin ext_mask = '1;                     ext_bit = 1'b0;           end
        endcase
        load_ext = (rd_shifted & ext_mask) | ({DATA_W{ext_bit & ~uns_q}} & ~ext_mask);
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        lane_d    = lane_q;
        size_d    = size_q;
        uns_d     = uns_q;
        is_wr_d   = is_wr_q;
        err_d     = err_q;
        code_d    = code_q;
        rd_data_d = rd_data_q;
        cnt_d     = cnt_q;
        ready     = is_wr_q ? d_wr_ready : d_rd_ready;

        unique case (state_q)
            IDLE: begin
                if (wr_en || rd_en) begin
                    is_wr_d = wr_en;
                    cnt_d   = '0;
                    if (illegal || misaligned) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        code_d  = illegal ? CODE_ILLEGAL : CODE_MISALGN;
                        if (!wr_en) rd_data_d = '0;
                    end else begin
                        state_d = REQ;
                        err_d   = 1'b0;
                        code_d  = CODE_NONE;
                        addr_d  = {rw_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
                        wdata_d = wr_data << {lane, 3'b000};
                        strb_d  = wr_en ? (strb_base << lane) : '0;
                        lane_d  = lane;
                        size_d  = size;
                        uns_d   = is_unsigned;
                    end
                end
            end
            REQ: begin
                // Ready on the final allowed cycle still wins over the timeout.
                if (ready) begin
                    state_d = RESP;
                    if (!is_wr_q) rd_data_d = load_ext;
                end else if (TIMEOUT > 0 && cnt_q == 32'(TIMEOUT - 1)) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    code_d  = CODE_TIMEOUT;
                    if (!is_wr_q) rd_data_d = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        d_wr_req  = (state_q == REQ) && is_wr_q;
        d_rd_req  = (state_q == REQ) && !is_wr_q;
        wr_done   = (state_q == RESP) && is_wr_q;
        rd_done   = (state_q == RESP) && !is_wr_q;
        err       = (state_q == RESP) && err_q;
        err_code  = (state_q == RESP) ? code_q : CODE_NONE;
        rd_data   = rd_data_q;
        d_addr    = addr_q;
        d_wr_data = wdata_q;
        d_wr_strb = strb_q;
    end

endmodule

// File: tb/tb_ls_unit.sv
// Scoreboard bench for ls_unit: a 32-bit instance with TIMEOUT=4 and a 64-bit instance without timeout.
module tb_ls_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstb;
    logic        sel;
    logic        wr_en, rd_en;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] rw_addr;
    logic [63:0] wr_data;
    logic [63:0] rd_src;
    logic        rdy;

    logic        a_busy, a_rd_done, a_wr_done, a_err, a_wr_req, a_rd_req;
    logic [1:0]  a_err_code;
    logic [31:0] a_rd_data, a_d_addr, a_d_wr_data;
    logic [3:0]  a_d_wr_strb;

    logic        b_busy, b_rd_done, b_wr_done, b_err, b_wr_req, b_rd_req;
    logic [1:0]  b_err_code;
    logic [63:0] b_rd_data, b_d_wr_data;
    logic [31:0] b_d_addr;
    logic [7:0]  b_d_wr_strb;

    ls_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) u32 (
        .clk(clk), .rstb(rstb), .rw_addr(rw_addr),
        .wr_en(wr_en & ~sel), .rd_en(rd_en & ~sel),
        .size(size), .is_unsigned(uns), .wr_data(wr_data[31:0]),
        .busy(a_busy), .rd_data(a_rd_data), .rd_done(a_rd_done), .wr_done(a_wr_done),
        .err(a_err), .err_code(a_err_code), .d_addr(a_d_addr),
        .d_wr_data(a_d_wr_data), .d_wr_strb(a_d_wr_strb),
        .d_wr_req(a_wr_req), .d_wr_ready(rdy), .d_rd_req(a_rd_req),
        .d_rd_ready(rdy), .d_rd_data(rd_src[31:0])
    );

    ls_unit #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(0)) u64 (
        .clk(clk), .rstb(rstb), .rw_addr(rw_addr),
        .wr_en(wr_en & sel), .rd_en(rd_en & sel),
        .size(size), .is_unsigned(uns), .wr_data(wr_data),
        .busy(b_busy), .rd_data(b_rd_data), .rd_done(b_rd_done), .wr_done(b_wr_done),
        .err(b_err), .err_code(b_err_code), .d_addr(b_d_addr),
        .d_wr_data(b_d_wr_data), .d_wr_strb(b_d_wr_strb),
        .d_wr_req(b_wr_req), .d_wr_ready(rdy), .d_rd_req(b_rd_req),
        .d_rd_ready(rdy), .d_rd_data(rd_src)
    );

    // Unified view of whichever instance is under test.
    logic        m_req, m_busy, m_rd_done, m_wr_done, m_err;
    logic [1:0]  m_code;
    logic [31:0] m_daddr;
    logic [7:0]  m_strb;
    logic [63:0] m_dwdata, m_rd_data;

    always_comb begin
        m_req     = sel ? (b_rd_req | b_wr_req) : (a_rd_req | a_wr_req);
        m_busy    = sel ? b_busy : a_busy;
        m_rd_done = sel ? b_rd_done : a_rd_done;
        m_wr_done = sel ? b_wr_done : a_wr_done;
        m_err     = sel ? b_err : a_err;
        m_code    = sel ? b_err_code : a_err_code;
        m_daddr   = sel ? b_d_addr : a_d_addr;
        m_strb    = sel ? b_d_wr_strb : {4'h0, a_d_wr_strb};
        m_dwdata  = sel ? b_d_wr_data : {32'h0, a_d_wr_data};
        m_rd_data = sel ? b_rd_data : {32'h0, a_rd_data};
    end

    typedef struct {
        logic        is_wr;
        logic        err;
        logic [1:0]  code;
        logic [63:0] rd;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   wait_cyc = 0;
    int   rcnt     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: ready rises on request cycle number wait_cyc (0 = first cycle).
    always @(negedge clk) begin
        if (m_req) begin
            rdy = (rcnt == wait_cyc);
            rcnt++;
        end else begin
            rdy  = 1'b0;
            rcnt = 0;
        end
    end

    // Monitor: every done pulse must match the oldest expected response.
    always @(negedge clk) begin
        exp_t e;
        if (sel ? (a_rd_done | a_wr_done) : (b_rd_done | b_wr_done))
            check("stray_done_idle_unit", 64'd1, 64'd0);
        if (m_rd_done | m_wr_done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("done_kind", {63'd0, m_wr_done}, {63'd0, e.is_wr});
                check("one_done", {63'd0, m_wr_done & m_rd_done}, 64'd0);
                check("err", {63'd0, m_err}, {63'd0, e.err});
                check("err_code", {62'd0, m_code}, {62'd0, e.code});
                if (!e.is_wr) check("rd_data", m_rd_data, e.rd);
            end
        end
    end

    task automatic txn(input logic w, input logic r, input logic [1:0] sz, input logic u,
                       input logic [31:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                       input int wt, input logic e_err, input logic [1:0] e_code,
                       input logic [63:0] e_rd, input int e_reqs, input int e_lat,
                       input logic [31:0] e_daddr, input logic [7:0] e_strb,
                       input logic [63:0] e_wdata, input string tag);
        int          reqs, lat;
        logic        stable;
        logic [31:0] a0;
        logic [7:0]  s0;
        logic [63:0] d0;
        exp_t        e;
        e.is_wr = w; e.err = e_err; e.code = e_code; e.rd = e_rd;
        sb.push_back(e);
        wr_en = w; rd_en = r; size = sz; uns = u; rw_addr = addr; wr_data = wd;
        rd_src = rd; wait_cyc = wt;
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
        reqs = 0; lat = 0; stable = 1'b1; a0 = '0; s0 = '0; d0 = '0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge clk);
            if (m_req) begin
                reqs++;
                if (reqs == 1) begin
                    a0 = m_daddr; s0 = m_strb; d0 = m_dwdata;
                end else if (m_daddr !== a0 || m_strb !== s0 || m_dwdata !== d0) begin
                    stable = 1'b0;
                end
            end
            if (m_rd_done | m_wr_done) lat = k;
        end
        check({tag, "_latency"}, 64'(lat), 64'(e_lat));
        check({tag, "_req_cycles"}, 64'(reqs), 64'(e_reqs));
        if (e_reqs > 0) begin
            check({tag, "_req_stable"}, {63'd0, stable}, 64'd1);
            check({tag, "_d_addr"}, {32'd0, a0}, {32'd0, e_daddr});
            if (w) begin
                check({tag, "_strb"}, {56'd0, s0}, {56'd0, e_strb});
                check({tag, "_d_wr_data"}, d0, e_wdata);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic seen;
        sel = 1'b0; rstb = 1'b1; wr_en = 1'b0; rd_en = 1'b0; size = 2'd0; uns = 1'b0;
        rw_addr = '0; wr_data = '0; rd_src = '0; rdy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {62'd0, a_busy, b_busy}, 64'd0);
        check("rst_req", {60'd0, a_rd_req, a_wr_req, b_rd_req, b_wr_req}, 64'd0);
        check("rst_rd_data", {a_rd_data, b_rd_data[31:0]} | {32'd0, b_rd_data[63:32]}, 64'd0);
        check("rst_err_code", {60'd0, a_err_code, b_err_code}, 64'd0);
        check("rst_strb", {52'd0, a_d_wr_strb, b_d_wr_strb}, 64'd0);
        check("rst_d_addr", {a_d_addr, b_d_addr}, 64'd0);
        @(posedge clk); #1;
        rstb = 1'b0;

        //   w  r  sz u  addr     wdata         rdata         wt    err code exp_rd        reqs lat daddr    strb  exp_wdata
        txn(1, 0, 2, 0, 'h100,  'hDEADBEEF,   0,            0,    0, 0,   0,            1,   2,  'h100,   'hF,  'hDEADBEEF, "sw");
        txn(1, 0, 0, 0, 'h103,  'hA5,         0,            0,    0, 0,   0,            1,   2,  'h100,   'h8,  'hA5000000, "sb");
        txn(0, 1, 1, 0, 'h102,  0,            'h80011234,   3,    0, 0,   'hFFFF8001,   4,   5,  'h100,   0,    0,          "lh_s");
        txn(0, 1, 1, 1, 'h102,  0,            'h80011234,   3,    0, 0,   'h00008001,   4,   5,  'h100,   0,    0,          "lh_u");
        txn(0, 1, 0, 1, 'h101,  0,            'h80011234,   1,    0, 0,   'h00000012,   2,   3,  'h100,   0,    0,          "lb_u");
        txn(0, 1, 0, 0, 'h103,  0,            'h80011234,   0,    0, 0,   'hFFFFFF80,   1,   2,  'h100,   0,    0,          "lb_s");
        txn(0, 1, 2, 0, 'h101,  0,            'h55555555,   0,    1, 1,   0,            0,   1,  0,       0,    0,          "lw_mis");
        txn(1, 0, 1, 0, 'h101,  'h1234,       0,            0,    1, 1,   0,            0,   1,  0,       0,    0,          "sh_mis");
        txn(1, 1, 2, 0, 'h100,  'h1,          0,            0,    1, 2,   0,            0,   1,  0,       0,    0,          "both_ill");
        txn(0, 1, 2, 0, 'h104,  0,            'h11223344,   0,    0, 0,   'h11223344,   1,   2,  'h104,   0,    0,          "lw");
        txn(0, 1, 3, 0, 'h100,  0,            'h11223344,   0,    1, 2,   0,            0,   1,  0,       0,    0,          "ld32_ill");
        txn(0, 1, 2, 0, 'h200,  0,            'h99999999,   1000, 1, 3,   0,            4,   5,  'h200,   0,    0,          "lw_to");
        txn(0, 1, 2, 0, 'h200,  0,            'hCAFEF00D,   3,    0, 0,   'hCAFEF00D,   4,   5,  'h200,   0,    0,          "lw_to_edge");

        // Reset while a load is waiting: request must drop and no done may follow.
        rw_addr = 'h300; size = 2'd2; rd_en = 1'b1; wait_cyc = 1000;
        @(posedge clk); #1;
        rd_en = 1'b0;
        @(negedge clk);
        check("rst_mid_req_before", {63'd0, m_req}, 64'd1);
        @(posedge clk); #1;
        rstb = 1'b1;
        @(posedge clk); #1;
        rstb = 1'b0;
        @(negedge clk);
        check("rst_mid_req_after", {63'd0, m_req}, 64'd0);
        check("rst_mid_busy", {63'd0, m_busy}, 64'd0);
        check("rst_mid_d_addr", {32'd0, m_daddr}, 64'd0);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (m_rd_done | m_wr_done | m_req) seen = 1'b1;
        end
        check("rst_mid_no_done", {63'd0, seen}, 64'd0);
        @(posedge clk); #1;

        sel = 1'b1;
        txn(0, 1, 3, 0, 'h8,    0,                  'h0123456789ABCDEF, 2, 0, 0, 'h0123456789ABCDEF, 3, 4, 'h8,  0,     0,                  "ld64");
        txn(1, 0, 3, 0, 'h10,   'h1122334455667788, 0,                  0, 0, 0, 0,                  1, 2, 'h10, 'hFF,  'h1122334455667788, "sd64");
        txn(0, 1, 2, 1, 'h4,    0,                  'h0123456789ABCDEF, 0, 0, 0, 'h0000000001234567, 1, 2, 'h0,  0,     0,                  "lwu64");
        txn(0, 1, 0, 0, 'hF,    0,                  'h80FFFFFFFFFFFFFF, 0, 0, 0, 'hFFFFFFFFFFFFFF80, 1, 2, 'h8,  0,     0,                  "lb64");
        txn(1, 0, 1, 0, 'hA,    'hBEEF,             0,                  0, 0, 0, 0,                  1, 2, 'h8,  'h0C,  'h00000000BEEF0000, "sh64");
        txn(0, 1, 3, 0, 'hC,    0,                  'h0,                0, 1, 1, 0,                  0, 1, 0,    0,     0,                  "ld64_mis");

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
